serial_alu: RTL



---
 rtl/serial_alu.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_alu.sv
// Bit-serial ALU: add, subtract, AND and XOR, one operand bit per clock, LSB first.
// A controller drives it through a start/busy/done handshake.
module serial_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   y
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [1:0]       op_sh;
    logic             cy;
    logic [IW-1:0]    idx;

    logic             bit_nxt;
    logic             cy_nxt;
    logic             last;
    logic             accept;

    // One-bit slice of the datapath; the operand shadows shift right so bit i is always at [0].
    always_comb begin
        bit_nxt = 1'b0;
        cy_nxt  = 1'b0;
        case (op_sh)
            2'b00: begin
                bit_nxt = a_sh[0] ^ b_sh[0] ^ cy;
                cy_nxt  = (a_sh[0] & b_sh[0]) | (b_sh[0] & cy) | (cy & a_sh[0]);
            end
            2'b01: begin
                bit_nxt = a_sh[0] ^ b_sh[0] ^ cy;
                cy_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & cy);
            end
            2'b10: bit_nxt = a_sh[0] & b_sh[0];
            2'b11: bit_nxt = a_sh[0] ^ b_sh[0];
            default: begin
                bit_nxt = 1'b0;
                cy_nxt  = 1'b0;
            end
        endcase
    end

    assign last   = (idx == IW'(WIDTH - 1));
    assign accept = (state != RUN) && start;

    // Next-state logic; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : IDLE;
            RUN:        state_nxt = last ? DONE : RUN;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand capture, serial shift and result publication; y only changes on completion.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_sh  <= 2'b00;
            cy     <= 1'b0;
            idx    <= '0;
            y      <= '0;
        end else if (accept) begin
            a_sh  <= p;
            b_sh  <= q;
            op_sh <= op;
            cy    <= 1'b0;
            idx   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {bit_nxt, res_sh[WIDTH-1:1]};
            cy     <= cy_nxt;
            idx    <= idx + IW'(1);
            if (last) begin
                y <= {cy_nxt, bit_nxt, res_sh[WIDTH-1:1]};
            end
        end
    end

endmodule
